data_mem_io_unit: RTL

//   Data-side memory for the single-cycle core: consumes memWrite, Addressmem and WriteDataMem,
//   and returns ReadData in the same cycle. Word RAM below IO_BASE. Memory-mapped TX port at or

---
 rtl/data_mem_io_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_mem_io_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_io_unit
//  Description : Data-side memory for a single-cycle core. Word RAM with
//                asynchronous read below IO_BASE, plus a memory-mapped TX
//                port whose stores enter a small FIFO that drains to an
//                external peripheral over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_io_unit #(
    parameter int             N       = 32,
    parameter int             RAM_AW  = 6,
    parameter int             DEPTH   = 4,
    parameter logic [N-1:0]   IO_BASE = 32'hFFFF_0000
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          memWrite,
    input  logic [N-1:0]  Addressmem,
    input  logic [N-1:0]  WriteDataMem,
    output logic [N-1:0]  ReadData,
    output logic          io_valid,
    output logic [N-1:0]  io_data,
    input  logic          io_ready,
    output logic          fifo_full,
    output logic          tx_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
    localparam logic [N-3:0]  C_OFF_TX    = '0;
    localparam logic [N-3:0]  C_OFF_STAT  = (N-2)'(1);
    localparam int            C_OVF_CLR_B = 10;

    // Storage arrays (no reset: RAM contents persist, FIFO slots are
    // meaningful only while counted as occupied)
    logic [N-1:0]  ram_q      [2**RAM_AW];
    logic [N-1:0]  fifo_mem_q [DEPTH];

    // Control state
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [CW-1:0] count_q,   count_d;
    logic          ovf_q,     ovf_d;

    // Decode
    logic              w_io_sel;
    logic [N-3:0]      w_io_word;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_ovf_clr;
    logic [N-1:0]      w_status;

    // Address decode and FIFO handshake terms
    always_comb begin
        w_io_sel  = (Addressmem >= IO_BASE);
        w_io_word = Addressmem[N-1:2] - IO_BASE[N-1:2];
        w_ram_idx = Addressmem[RAM_AW+1:2];
        w_full    = (count_q == C_DEPTH);
        w_empty   = (count_q == '0);
        w_push    = memWrite && w_io_sel && (w_io_word == C_OFF_TX);
        w_pop     = !w_empty && io_ready;
        // A full FIFO still accepts a store when the head leaves this cycle
        w_push_ok = w_push && (!w_full || w_pop);
        w_ovf_clr = memWrite && w_io_sel && (w_io_word == C_OFF_STAT)
                    && WriteDataMem[C_OVF_CLR_B];
    end

    // Next-state for pointers, occupancy and sticky overflow flag
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (w_push_ok && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push_ok && w_pop) begin
            count_d = count_q - CW'(1);
        end
        if (w_push && !w_push_ok) begin
            ovf_d = 1'b1;
        end else if (w_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Word RAM write port
    always_ff @(posedge CLK) begin
        if (memWrite && !w_io_sel) begin
            ram_q[w_ram_idx] <= WriteDataMem;
        end
    end

    // FIFO slot write; on full+pop the slot written is the departing head
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            fifo_mem_q[wr_ptr_q] <= WriteDataMem;
        end
    end

    // Load path: RAM or IO registers, purely combinational
    always_comb begin
        w_status                = '0;
        w_status[10]            = ovf_q;
        w_status[9]             = w_empty;
        w_status[8]             = w_full;
        w_status[7:0]           = 8'(count_q);
        ReadData                = '0;
        if (!w_io_sel) begin
            ReadData = ram_q[w_ram_idx];
        end else if (w_io_word == C_OFF_STAT) begin
            ReadData = w_status;
        end
    end

    // Peripheral-facing outputs
    always_comb begin
        io_valid    = !w_empty;
        io_data     = fifo_mem_q[rd_ptr_q];
        fifo_full   = w_full;
        tx_overflow = ovf_q;
    end

endmodule
`default_nettype wire
